tank_move_controller: RTL and testbench

TANK_MOVE_CONTROLLER -- requirements
Module: tank_move_controller

---
 rtl/tank_pkg.sv | 11 +
 rtl/tank_step_clamp.sv | 29 ++
 rtl/tank_move_controller.sv | 71 +++++++
 tb/tb_tank_move_controller.sv | 90 +++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// tank_pkg: shared types, screen geometry and the direction-priority helper for the tank mover
package tank_pkg;
  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;
  typedef enum logic [1:0] {IDLE, CHECK, ROLLBACK, STEP} state_t;
  localparam int TANK_SIZE = 25;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  function automatic dir_t pick_dir(input logic [3:0] req);
    return req[0] ? UP : req[1] ? RIGHT : req[2] ? DOWN : LEFT;
  endfunction
endpackage

// File: rtl/tank_step_clamp.sv
// tank_step_clamp: moves (x,y) by speed toward dir, clamped to [0,X_MAX]/[0,Y_MAX], ports x,y,dir,speed -> next_x,next_y
module tank_step_clamp
  import tank_pkg::*;
#(
  parameter int X_MAX = SCREEN_W - TANK_SIZE,
  parameter int Y_MAX = SCREEN_H - TANK_SIZE
) (
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  dir_t        dir,
  input  logic [10:0] speed,
  output logic [10:0] next_x,
  output logic [10:0] next_y
);
  localparam logic [11:0] XM = 12'(X_MAX);
  localparam logic [11:0] YM = 12'(Y_MAX);
  logic [11:0] wx, wy, ws, xp, yp;
  assign wx = {1'b0, x};
  assign wy = {1'b0, y};
  assign ws = {1'b0, speed};
  assign xp = wx + ws;
  assign yp = wy + ws;
  always_comb begin
    next_x = dir == RIGHT ? (xp > XM ? XM[10:0] : xp[10:0]) :
             dir == LEFT  ? (wx < ws ? 11'd0 : x - speed) : x;
    next_y = dir == DOWN  ? (yp > YM ? YM[10:0] : yp[10:0]) :
             dir == UP    ? (wy < ws ? 11'd0 : y - speed) : y;
  end
endmodule

// File: rtl/tank_move_controller.sv
// tank_move_controller: per-frame tank mover with collision rollback; ins enable/startOfFrame/moveReq/collision, outs topLeftX/Y, tankDir, moving
module tank_move_controller
  import tank_pkg::*;
#(
  parameter int INIT_X = 100,
  parameter int INIT_Y = 100,
  parameter int SPEED = 2,
  parameter int X_MAX = SCREEN_W - TANK_SIZE,
  parameter int Y_MAX = SCREEN_H - TANK_SIZE
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        enable,
  input  logic        startOfFrame,
  input  logic [3:0]  moveReq,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  tankDir,
  output logic        moving
);
  state_t state;
  logic [10:0] prev_x, prev_y, nx, ny;
  logic col_latch;
  dir_t sel_dir;
  assign sel_dir = pick_dir(moveReq);
  tank_step_clamp #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_clamp (
    .x(topLeftX),
    .y(topLeftY),
    .dir(sel_dir),
    .speed(11'(SPEED)),
    .next_x(nx),
    .next_y(ny)
  );
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      topLeftX <= 11'(INIT_X);
      topLeftY <= 11'(INIT_Y);
      prev_x <= 11'(INIT_X);
      prev_y <= 11'(INIT_Y);
      tankDir <= 2'b00;
      moving <= 1'b0;
      col_latch <= 1'b0;
    end else begin
      // the rollback edge clears the latch even if collision is high then
      col_latch <= state == ROLLBACK ? 1'b0 : col_latch | collision;
      case (state)
        IDLE: state <= startOfFrame && enable ? CHECK : IDLE;
        CHECK: state <= col_latch ? ROLLBACK : STEP;
        ROLLBACK: begin
          topLeftX <= prev_x;
          topLeftY <= prev_y;
          moving <= 1'b0;
          state <= IDLE;
        end
        STEP: begin
          if (|moveReq) begin
            tankDir <= sel_dir;
            prev_x <= topLeftX;
            prev_y <= topLeftY;
            topLeftX <= nx;
            topLeftY <= ny;
            moving <= nx != topLeftX || ny != topLeftY;
          end else moving <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tank_move_controller.sv
// tb_tank_move_controller: directed checks of two tank movers (default and near-edge start) sharing one stimulus
module tb_tank_move_controller;
  logic clk = 0, resetN = 0, enable = 0, sof = 0, collision = 0;
  logic [3:0] move_req = 0;
  logic [10:0] x1, y1, x2, y2, ex1, ey1, ex2, ey2;
  logic [1:0] d1, d2, ed1, ed2;
  logic m1, m2, em1, em2;
  int n_assert = 0, n_fail = 0;
  always #5 clk = ~clk;
  tank_move_controller dut (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(sof), .moveReq(move_req),
    .collision(collision), .topLeftX(x1), .topLeftY(y1), .tankDir(d1), .moving(m1)
  );
  tank_move_controller #(.INIT_X(614), .INIT_Y(1)) dut_edge (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(sof), .moveReq(move_req),
    .collision(collision), .topLeftX(x2), .topLeftY(y2), .tankDir(d2), .moving(m2)
  );
  task automatic ck(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    ck({tag, " x"}, x1, ex1);
    ck({tag, " y"}, y1, ey1);
    ck({tag, " dir"}, 11'(d1), 11'(ed1));
    ck({tag, " moving"}, 11'(m1), 11'(em1));
    ck({tag, " edge x"}, x2, ex2);
    ck({tag, " edge y"}, y2, ey2);
    ck({tag, " edge dir"}, 11'(d2), 11'(ed2));
    ck({tag, " edge moving"}, 11'(m2), 11'(em2));
  endtask
  task automatic set_exp(input int a, b, c, d, e, f, g, h);
    ex1 = 11'(a); ey1 = 11'(b); ed1 = 2'(c); em1 = 1'(d);
    ex2 = 11'(e); ey2 = 11'(f); ed2 = 2'(g); em2 = 1'(h);
  endtask
  // SOF pulse, optional collision in the SOF / third cycle, optional enable drop after SOF
  task automatic frame(input string tag, input logic [3:0] mr, input logic cs, input logic cr,
                       input logic de, input int a, b, c, d, e, f, g, h);
    @(negedge clk); sof = 1; move_req = mr; collision = cs;
    @(negedge clk); sof = 0; collision = 0; if (de) enable = 0;
    @(negedge clk); chk_all({tag, " hold"}); collision = cr;
    @(negedge clk); collision = 0; enable = 1;
    set_exp(a, b, c, d, e, f, g, h);
    chk_all(tag);
  endtask
  initial begin
    set_exp(100, 100, 0, 0, 614, 1, 0, 0);
    repeat (2) @(negedge clk);
    chk_all("reset");
    resetN = 1; enable = 1;
    frame("right", 4'b0010, 0, 0, 0, 102, 100, 1, 1, 615, 1, 1, 1);
    @(negedge clk); collision = 1;
    @(negedge clk); collision = 0;
    frame("rollback", 4'b0000, 0, 0, 0, 100, 100, 1, 0, 614, 1, 1, 0);
    frame("after rb", 4'b0010, 0, 0, 0, 102, 100, 1, 1, 615, 1, 1, 1);
    frame("x clamp", 4'b0010, 0, 0, 0, 104, 100, 1, 1, 615, 1, 1, 0);
    frame("up clamp", 4'b0001, 0, 0, 0, 104, 98, 0, 1, 615, 0, 0, 1);
    frame("y at 0", 4'b0001, 0, 0, 0, 104, 96, 0, 1, 615, 0, 0, 0);
    @(negedge clk); sof = 1; move_req = 4'b0010;
    @(negedge clk); sof = 0; resetN = 0;
    #1 set_exp(100, 100, 0, 0, 614, 1, 0, 0);
    chk_all("reset in check");
    @(negedge clk); chk_all("reset held");
    resetN = 1;
    frame("prio 1111", 4'b1111, 0, 0, 0, 100, 98, 0, 1, 614, 0, 0, 1);
    frame("prio 0110", 4'b0110, 0, 0, 0, 102, 98, 1, 1, 615, 0, 1, 1);
    frame("prio 1100", 4'b1100, 0, 0, 0, 102, 100, 2, 1, 615, 2, 2, 1);
    frame("left", 4'b1000, 0, 0, 0, 100, 100, 3, 1, 613, 2, 3, 1);
    frame("no req", 4'b0000, 0, 0, 0, 100, 100, 3, 0, 613, 2, 3, 0);
    enable = 0; move_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sof = 1; collision = (i == 1);
      @(negedge clk); sof = 0; collision = 0;
      repeat (3) @(negedge clk);
      chk_all("freeze");
    end
    enable = 1;
    frame("frozen col", 4'b0100, 0, 0, 0, 102, 100, 3, 0, 615, 2, 3, 0);
    frame("down", 4'b0100, 0, 0, 0, 102, 102, 2, 1, 615, 4, 2, 1);
    frame("col at sof", 4'b0100, 1, 1, 0, 102, 100, 2, 0, 615, 2, 2, 0);
    frame("clear wins", 4'b0100, 0, 0, 1, 102, 102, 2, 1, 615, 4, 2, 1);
    @(negedge clk); ck("enable restored", 11'(enable), 11'd1);
    frame("enable ok", 4'b0001, 0, 0, 0, 102, 100, 0, 1, 615, 2, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
